usb_send_arbiter: RTL and testbench
===================================

Name: usb_send_arbiter

Overview:
- Shares the single usb send channel (fs_send / send_btype / fd_send handshake) among NREQ independent requesters, e.g. link, type/param and data reply paths.
- Round-robin arbitration; the selected packet type is latched and fs_send is held until the usb core reports fd_send.
- Enforces a minimum inter-packet gap after each send.
- Sits between the top-level command-decode FSM and the usb core's send side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP, 8'h40, idle cycles inserted after each completed or aborted send (0 = none).
- TOUT, 16'hFFFF, SEND-state cycle limit; used only with SEND_TOUT_EN.

Ports:
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-requester level request; held until its ack pulse.
- req_btype  in  4*NREQ  packet type per requester, slice i = [4i+3:4i]; stable while req[i] is high.
- ack  out  NREQ  one-cycle pulse to the served requester when its send completes.
- busy  out  1  high in every state except IDLE.
- fs_send  out  1  send start to usb core; high for the whole SEND state.
- send_btype  out  4  latched packet type presented to usb core.
- fd_send  in  1  send done from usb core.
- err_tout  out  1  one-cycle pulse on send timeout; constant 0 without SEND_TOUT_EN.

Behaviour:
- Reset (async, immediate, also mid-operation) values:
  - state = IDLE, ptr = 0, idx = 0, gap_cnt = 0.
  - send_btype = 4'b0000, ack = 0, err_tout = 0, fs_send = 0, busy = 0.
  - A send in flight is dropped; no ack is issued for it.
- Outputs decoded from the state register:
  - fs_send = (state == SEND).
  - busy = (state != IDLE).
- States and transitions:
  - IDLE: if |req, go to ARB; otherwise stay.
  - ARB (1 cycle):
    - Pick the lowest i with req[i], searching from ptr upward and wrapping at NREQ.
    - Latch idx <= i and send_btype <= req_btype slice i, then go to SEND.
    - If req is all zero in this cycle, return to IDLE with no latch.
  - SEND:
    - Hold fs_send = 1; fd_send is sampled only in this state.
    - On fd_send = 1, go to DONE.
    - A requester dropping req during SEND is ignored; the send still completes and its ack still pulses.
  - DONE (1 cycle): ack[idx] = 1; ptr <= (idx == NREQ-1) ? 0 : idx+1. Go to WAIT_LOW.
  - WAIT_LOW: stay until fd_send = 0. Then go to GAP, or to IDLE when GAP = 0.
  - GAP:
    - gap_cnt counts 0 .. GAP-1; on gap_cnt == GAP-1, go to IDLE.
    - gap_cnt clears in every other state.
- Latency: req[i] rises before clock edge k; ARB after edge k; fs_send high after edge k+1. Throughput is 1 packet per (send time + GAP + 4) cycles minimum.
- send_btype is never updated outside ARB; it holds its last value while idle.
- ack is never asserted for more than one bit or for more than one cycle.
- Fairness: a requester that is continuously requesting is served within NREQ grants.
- Undefined, but must not hang: req_btype changing while req is high. The latched value is the one used.

Optional Feature:
- Macro: SEND_TOUT_EN.
- Defined:
  - A 16-bit tout_cnt counts while in SEND.
  - On tout_cnt == TOUT-1 with fd_send still 0: pulse err_tout for 1 cycle, issue no ack, advance ptr as in DONE, go to WAIT_LOW.
  - If fd_send and the timeout coincide, fd_send wins: normal DONE, no err_tout.
- Undefined: no counter; SEND waits indefinitely; err_tout tied 0.

Decomposition:
- Shared package (usb_pkg): BAG_* 4-bit packet-type constants (BAG_INIT, BAG_DIDX, BAG_DPARAM, BAG_DDIDX, ...) and the arbiter state encodings (IDLE, ARB, SEND, DONE, WAIT_LOW, GAP).
- Sub-module usb_rr_pick: combinational round-robin picker (req, ptr -> idx, valid).
- FSM, counters and latches stay in usb_send_arbiter.

Test Plan:
- Single request, NREQ=4, GAP=8'h40: req[2]=1 with btype 4'b0101; fd_send raised 10 cycles after fs_send -> send_btype=4'b0101 during SEND, fs_send high exactly until fd_send sampled, ack=4'b0100 one cycle, next ARB no earlier than 64 cycles after fd_send falls.
- Round-robin: req=4'b1111 held, each ack drops its req and reasserts next cycle -> ack order 0,1,2,3,0 and send_btype matches each slice.
- Request withdrawn: req[1] pulsed for 1 cycle (seen by IDLE, gone at ARB) -> return to IDLE, fs_send never rises, no ack.
- Mid-send reset: rst asserted during SEND -> fs_send, busy, send_btype, ack all 0 same cycle; ptr=0 after release.
- fd_send held high after send: fd_send stuck high 20 cycles past DONE -> stays in WAIT_LOW; GAP starts only after fd_send falls; single ack.
- SEND_TOUT_EN with TOUT=16'h0010, fd_send never asserted -> err_tout pulse 16 cycles after SEND entry, no ack, ptr advanced, busy returns to 0 after GAP.

Source files
------------

// File: rtl/usb_pkg.sv
// usb_pkg
// Shared definitions for the usb send path.
//   - BAG_* : 4-bit packet-type codes that requesters put on req_btype.
//   - arbState_t : state encoding of the usb_send_arbiter FSM.
//   - ptrWidth / wrapAdd : small helpers for sizing and walking the
//     requester ring.
package usb_pkg;

  localparam logic [3:0] BAG_NONE   = 4'h0;
  localparam logic [3:0] BAG_INIT   = 4'h1;
  localparam logic [3:0] BAG_DIDX   = 4'h2;
  localparam logic [3:0] BAG_DPARAM = 4'h3;
  localparam logic [3:0] BAG_DDIDX  = 4'h4;
  localparam logic [3:0] BAG_DDATA  = 4'h5;
  localparam logic [3:0] BAG_STATUS = 4'h6;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_ARB      = 3'd1,
    ARB_SEND     = 3'd2,
    ARB_DONE     = 3'd3,
    ARB_WAIT_LOW = 3'd4,
    ARB_GAP      = 3'd5
  } arbState_t;

  // Bits needed to hold a requester index; never less than one.
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (a + b) mod n for a, b already below n.
  function automatic int wrapAdd(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// usb_rr_pick
// Combinational round-robin picker: returns the first active request found
// when walking the ring upward from ptr_i, wrapping at NREQ.
// Ports:
//   req_i   [NREQ-1:0] active requests
//   ptr_i   [PW-1:0]   highest-priority position this round
//   idx_o   [PW-1:0]   chosen requester (0 when valid_o is low)
//   valid_o            at least one request is active
module usb_rr_pick
  import usb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = ptrWidth(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  logic [PW-1:0] cand;

  // Walk from the farthest ring offset back to offset 0 so the nearest
  // active request to ptr_i is the last one written and therefore wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'(wrapAdd(int'(ptr_i), k, NREQ));
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_send_arbiter.sv
// usb_send_arbiter
// Shares the usb core's single send channel among NREQ requesters with
// round-robin arbitration, a latched packet type and a minimum idle gap
// after every send.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req        [NREQ]    level requests, held until ack
//   req_btype  [4*NREQ]  packet type per requester, slice i = [4i+3:4i]
//   ack        [NREQ]    one-cycle pulse to the served requester
//   busy                 FSM not idle
//   fs_send              send start, high for the whole SEND state
//   send_btype [4]       latched packet type for the usb core
//   fd_send              send done from the usb core
//   err_tout             one-cycle pulse when a send times out
// Optional feature: define SEND_TOUT_EN to abort a send that has not seen
// fd_send within TOUT cycles; without it err_tout is tied low.
module usb_send_arbiter
  import usb_pkg::*;
#(
  parameter int          NREQ = 4,
  parameter logic [7:0]  GAP  = 8'h40,
  parameter logic [15:0] TOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_btype,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic              fs_send,
  output logic [3:0]        send_btype,
  input  logic              fd_send,
  output logic              err_tout
);

  localparam int            PW   = ptrWidth(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  arbState_t     state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [3:0]    btype_q, btype_d;
  logic [7:0]    gapCnt_q, gapCnt_d;

  logic [PW-1:0] pickIdx;
  logic          pickValid;
  logic [PW-1:0] nextPtr;
  logic [3:0]    btypeSlice [NREQ];

`ifdef SEND_TOUT_EN
  logic [15:0] toutCnt_q, toutCnt_d;
  logic        errTout_q, errTout_d;
`endif

  usb_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      btypeSlice[i] = req_btype[4*i +: 4];
    end
  end

  // After serving (or timing out) idx_q, the requester just above it gets
  // first priority next round.
  assign nextPtr = (idx_q == LAST) ? '0 : idx_q + 1'b1;

  assign fs_send    = (state_q == ARB_SEND);
  assign busy       = (state_q != ARB_IDLE);
  assign send_btype = btype_q;

  always_comb begin
    ack = '0;
    if (state_q == ARB_DONE) begin
      ack[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      btype_q  <= 4'b0000;
      gapCnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      btype_q  <= btype_d;
      gapCnt_q <= gapCnt_d;
    end
  end

`ifdef SEND_TOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toutCnt_q <= 16'd0;
      errTout_q <= 1'b0;
    end else begin
      toutCnt_q <= toutCnt_d;
      errTout_q <= errTout_d;
    end
  end

  // Registered so the pulse lands in the first WAIT_LOW cycle after the
  // aborted send, cleanly aligned with the clock.
  assign err_tout = errTout_q;
`else
  logic unusedTout;
  assign unusedTout = ^TOUT;
  assign err_tout   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    btype_d  = btype_q;
    gapCnt_d = 8'd0;
`ifdef SEND_TOUT_EN
    toutCnt_d = 16'd0;
    errTout_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d = ARB_ARB;
        end
      end
      // A request seen in IDLE may already be gone here; then nothing is
      // latched and the FSM drops back to IDLE.
      ARB_ARB: begin
        if (pickValid) begin
          idx_d   = pickIdx;
          btype_d = btypeSlice[pickIdx];
          state_d = ARB_SEND;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      // fd_send is checked first so a completion coinciding with the
      // timeout is treated as a normal send.
      ARB_SEND: begin
        if (fd_send) begin
          state_d = ARB_DONE;
        end
`ifdef SEND_TOUT_EN
        else if (toutCnt_q == TOUT - 16'd1) begin
          ptr_d     = nextPtr;
          errTout_d = 1'b1;
          state_d   = ARB_WAIT_LOW;
        end else begin
          toutCnt_d = toutCnt_q + 16'd1;
        end
`endif
      end
      ARB_DONE: begin
        ptr_d   = nextPtr;
        state_d = ARB_WAIT_LOW;
      end
      ARB_WAIT_LOW: begin
        if (!fd_send) begin
          state_d = (GAP == 8'd0) ? ARB_IDLE : ARB_GAP;
        end
      end
      ARB_GAP: begin
        if (gapCnt_q == GAP - 8'd1) begin
          state_d = ARB_IDLE;
        end else begin
          gapCnt_d = gapCnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_send_arbiter.sv
// tb_usb_send_arbiter
// Self-checking bench for usb_send_arbiter (NREQ=4, GAP=8'h40, TOUT=16'h0010).
// Expected grants are queued when requests are driven and compared when
// ack pulses. The timeout scenario runs only when SEND_TOUT_EN is defined.
module tb_usb_send_arbiter;

  localparam int          NREQ = 4;
  localparam logic [7:0]  GAP  = 8'h40;
  localparam logic [15:0] TOUT = 16'h0010;
`ifdef SEND_TOUT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_btype;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              fs_send;
  logic [3:0]        send_btype;
  logic              fd_send;
  logic              err_tout;

  usb_send_arbiter #(
    .NREQ (NREQ),
    .GAP  (GAP),
    .TOUT (TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_btype  (req_btype),
    .ack        (ack),
    .busy       (busy),
    .fs_send    (fs_send),
    .send_btype (send_btype),
    .fd_send    (fd_send),
    .err_tout   (err_tout)
  );

  typedef struct {
    int         idx;
    logic [3:0] btype;
  } expT;

  expT expQ[$];
  expT e;

  int total = 0;
  int bad   = 0;

  // Scenario controls shared with the monitor and usb core model.
  int              cyc          = 0;
  int              riseCyc      = 0;
  int              lastAckCyc   = 0;
  int              fsLen        = 0;
  int              expFsLen     = 10;
  int              expGapDelta  = 0;
  bit              armGap       = 0;
  int              acksSeen     = 0;
  int              errSeen      = 0;
  int              reassertLeft = 0;
  logic [NREQ-1:0] pending      = '0;
  logic            fsPrev       = 1'b0;
  logic [NREQ-1:0] ackPrev      = '0;
  bit              coreEn       = 1;
  int              fdDelay      = 10;
  int              fdHold       = 1;
  int              sendCnt      = 0;
  int              holdCnt      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // usb core model: raises fd_send after fdDelay cycles of fs_send and
  // keeps it high for fdHold cycles.
  initial begin
    fd_send = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !coreEn) begin
        fd_send = 1'b0;
        sendCnt = 0;
        holdCnt = 0;
      end else if (fd_send) begin
        holdCnt++;
        if (holdCnt >= fdHold) begin
          fd_send = 1'b0;
          holdCnt = 0;
        end
      end else if (fs_send) begin
        sendCnt++;
        if (sendCnt == fdDelay) begin
          fd_send = 1'b1;
          sendCnt = 0;
        end
      end else begin
        sendCnt = 0;
      end
    end
  end

  // Monitor and requester model, sampled 1 ns after each rising edge.
  // Requesters drop their line on ack and optionally reassert next cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        fsPrev  = 1'b0;
        ackPrev = '0;
        fsLen   = 0;
        pending = '0;
      end else begin
        req     = req | pending;
        pending = '0;
        if (fs_send && !fsPrev) begin
          riseCyc = cyc;
          if (expQ.size() > 0) checkOutput("sendBtype", send_btype, expQ[0].btype);
          if (armGap) begin
            checkOutput("gapDelta", cyc - lastAckCyc, expGapDelta);
            armGap = 0;
          end
        end
        if (fs_send) fsLen++;
        if (!fs_send && fsPrev) begin
          if (expFsLen != 0) checkOutput("fsLen", fsLen, expFsLen);
          fsLen = 0;
        end
        if (ack != '0) begin
          checkOutput("ackPulse", ackPrev, 0);
          if (expQ.size() == 0) begin
            checkOutput("ackUnexpected", ack, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("ackIdx", ack, 32'd1 << e.idx);
            checkOutput("ackBtype", send_btype, e.btype);
          end
          lastAckCyc = cyc;
          acksSeen++;
          req = req & ~ack;
          if (reassertLeft > 0) begin
            pending = ack;
            reassertLeft--;
          end
        end
        if (err_tout) begin
          errSeen++;
          checkOutput("errDelay", cyc - riseCyc, 16);
        end
        fsPrev  = fs_send;
        ackPrev = ack;
      end
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] mask, input int reassert);
    @(negedge clk);
    reassertLeft = reassert;
    req = req | mask;
  endtask

  task automatic pushExp(input int idx);
    expT x;
    x.idx   = idx;
    x.btype = req_btype[4*idx +: 4];
    expQ.push_back(x);
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (n < limit && !(busy == 1'b0 && expQ.size() == 0 && req == '0)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleReached", (n < limit), 1);
  endtask

  task automatic waitAcks(input int target, input int limit);
    int n;
    n = 0;
    while (n < limit && acksSeen < target) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ackReached", (n < limit), 1);
  endtask

  task automatic waitFsSend(input int limit);
    int n;
    n = 0;
    while (n < limit && !fs_send) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fsRise", fs_send, 1);
  endtask

  initial begin
    logic [3:0] savedBtype;
    bit         anyFs;
    int         base;

    rst       = 1'b1;
    req       = '0;
    req_btype = {4'hC, 4'h5, 4'h9, 4'h3};
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstFs", fs_send, 0);
    checkOutput("rstAck", ack, 0);
    checkOutput("rstBtype", send_btype, 0);
    checkOutput("rstErr", err_tout, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] round robin, all four requesting");
    for (int i = 0; i < 8; i++) pushExp(i % NREQ);
    applyStimulus(4'b1111, 4);
    waitIdle(3000);

    $display("[TB] single request on req[2], then gap timing");
    pushExp(2);
    pushExp(2);
    base = acksSeen;
    applyStimulus(4'b0100, 1);
    waitAcks(base + 1, 200);
    expGapDelta = 68;
    armGap      = 1;
    waitIdle(400);

    $display("[TB] withdrawn request");
    @(negedge clk);
    savedBtype = send_btype;
    req[1] = 1'b1;
    @(negedge clk);
    checkOutput("withdrawArb", busy, 1);
    req[1] = 1'b0;
    @(negedge clk);
    checkOutput("withdrawIdle", busy, 0);
    anyFs = 0;
    repeat (10) begin
      @(negedge clk);
      anyFs = anyFs | fs_send;
    end
    checkOutput("withdrawNoSend", anyFs, 0);
    checkOutput("withdrawBtype", send_btype, savedBtype);

    $display("[TB] reset during send");
    pushExp(1);
    applyStimulus(4'b0010, 0);
    waitIdle(400);
    coreEn   = 0;
    expFsLen = 0;
    applyStimulus(4'b1000, 0);
    waitFsSend(50);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    checkOutput("midRstFs", fs_send, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstBtype", send_btype, 0);
    checkOutput("midRstAck", ack, 0);
    @(negedge clk);
    rst    = 1'b0;
    coreEn = 1;
    @(negedge clk);
    expFsLen = 10;
    pushExp(1);
    pushExp(3);
    applyStimulus(4'b1010, 0);
    waitIdle(800);

    $display("[TB] fd_send stuck high after done");
    fdHold = 20;
    pushExp(0);
    pushExp(0);
    base = acksSeen;
    applyStimulus(4'b0001, 1);
    waitAcks(base + 1, 200);
    expGapDelta = 86;
    armGap      = 1;
    repeat (10) @(negedge clk);
    checkOutput("stuckBusy", busy, 1);
    checkOutput("stuckNoFs", fs_send, 0);
    waitIdle(600);
    fdHold = 1;

`ifdef SEND_TOUT_EN
    $display("[TB] send timeout");
    coreEn   = 0;
    expFsLen = 16;
    base     = errSeen;
    applyStimulus(4'b0100, 0);
    begin
      int n;
      n = 0;
      while (n < 200 && errSeen == base) begin
        @(negedge clk);
        n++;
      end
      checkOutput("errReached", (n < 200), 1);
    end
    checkOutput("toutBusy", busy, 1);
    coreEn   = 1;
    expFsLen = 10;
    pushExp(3);
    pushExp(2);
    req[3] = 1'b1;
    waitIdle(800);
`endif

    checkOutput("errCount", errSeen, EXP_ERR);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
